// File: rtl/zynq_aes_top.sv
// zynq_aes_top: AXI4-Stream request parser with ECB/CBC chaining in front of an
// external iterative AES round engine; each result block streams back as 4 words.
module zynq_aes_top #(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s00_axis_tdata,
  input  logic              s00_axis_tvalid,
  output logic              s00_axis_tready,
  input  logic              s00_axis_tlast,
  output logic [DATA_W-1:0] m00_axis_tdata,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic              m00_axis_tlast,
  output logic              eng_start,
  output logic              eng_decrypt,
  output logic [127:0]      eng_key,
  output logic [127:0]      eng_din,
  input  logic              eng_done,
  input  logic [127:0]      eng_dout
);
  typedef enum logic [2:0] {IDLE, KEY, IV, DATA_IN, ENGINE, DATA_OUT} state_t;

  state_t       state;
  logic [1:0]   word_cnt;
  logic         cbc;
  logic         iv_flag;
  logic         last_blk;
  logic [95:0]  stage;
  logic [127:0] blk;
  logic [127:0] chain;
  logic [127:0] result;
  logic [127:0] full_blk;
  logic [127:0] eng_res;
  logic         s_hs;
  logic         m_hs;
  logic         word3;

  // Stream words are little-endian while block byte 0 is the MSB, so each word is byte-swapped.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign s_hs     = s00_axis_tvalid & s00_axis_tready;
  assign m_hs     = m00_axis_tvalid & m00_axis_tready;
  assign word3    = (word_cnt == 2'd3);
  assign full_blk = {stage, bswap(s00_axis_tdata)};
  assign eng_res  = (cbc && eng_decrypt) ? (eng_dout ^ chain) : eng_dout;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state           <= IDLE;
      word_cnt        <= 2'd0;
      cbc             <= 1'b0;
      iv_flag         <= 1'b0;
      last_blk        <= 1'b0;
      stage           <= '0;
      blk             <= '0;
      chain           <= '0;
      result          <= '0;
      s00_axis_tready <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      eng_start       <= 1'b0;
      eng_decrypt     <= 1'b0;
      eng_key         <= '0;
      eng_din         <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          s00_axis_tready <= 1'b1;
          if (s_hs) begin
            eng_decrypt <= ~s00_axis_tdata[0];
            cbc         <= s00_axis_tdata[2];
            iv_flag     <= s00_axis_tdata[3];
            word_cnt    <= 2'd0;
            if (s00_axis_tlast)         state <= IDLE;
            else if (s00_axis_tdata[1]) state <= KEY;
            else if (s00_axis_tdata[3]) state <= IV;
            else                        state <= DATA_IN;
          end
        end
        KEY: begin
          if (s_hs) begin
            stage    <= full_blk[95:0];
            word_cnt <= word_cnt + 2'd1;
            if (word3) begin
              eng_key <= full_blk;
              if (s00_axis_tlast) state <= IDLE;
              else if (iv_flag)   state <= IV;
              else                state <= DATA_IN;
            end else if (s00_axis_tlast) begin
              state <= IDLE;
            end
          end
        end
        IV: begin
          if (s_hs) begin
            stage    <= full_blk[95:0];
            word_cnt <= word_cnt + 2'd1;
            if (word3) begin
              chain <= full_blk;
              state <= s00_axis_tlast ? IDLE : DATA_IN;
            end else if (s00_axis_tlast) begin
              state <= IDLE;
            end
          end
        end
        DATA_IN: begin
          if (s_hs) begin
            stage    <= full_blk[95:0];
            word_cnt <= word_cnt + 2'd1;
            if (word3) begin
              blk             <= full_blk;
              eng_din         <= (cbc && !eng_decrypt) ? (full_blk ^ chain) : full_blk;
              eng_start       <= 1'b1;
              last_blk        <= s00_axis_tlast;
              s00_axis_tready <= 1'b0;
              state           <= ENGINE;
            end else if (s00_axis_tlast) begin
              state <= IDLE;
            end
          end
        end
        ENGINE: begin
          if (eng_done) begin
            // The chain always tracks the ciphertext side of the block just processed.
            chain           <= eng_decrypt ? blk : eng_dout;
            result          <= eng_res;
            m00_axis_tdata  <= bswap(eng_res[127:96]);
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= 1'b0;
            word_cnt        <= 2'd0;
            state           <= DATA_OUT;
          end
        end
        DATA_OUT: begin
          if (m_hs) begin
            word_cnt <= word_cnt + 2'd1;
            if (word3) begin
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              s00_axis_tready <= 1'b1;
              state           <= last_blk ? IDLE : DATA_IN;
            end else begin
              result         <= {result[95:0], 32'h0};
              m00_axis_tdata <= bswap(result[95:64]);
              m00_axis_tlast <= last_blk && (word_cnt == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zynq_aes_top.sv
// tb_zynq_aes_top: random-stimulus bench with a packet-level AES/ECB/CBC model,
// an emulated AES engine and a per-cycle output scoreboard.
module tb_zynq_aes_top;
  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  s00_axis_tdata;
  logic         s00_axis_tvalid;
  logic         s00_axis_tready;
  logic         s00_axis_tlast;
  logic [31:0]  m00_axis_tdata;
  logic         m00_axis_tvalid;
  logic         m00_axis_tready;
  logic         m00_axis_tlast;
  logic         eng_start;
  logic         eng_decrypt;
  logic [127:0] eng_key;
  logic [127:0] eng_din;
  logic         eng_done;
  logic [127:0] eng_dout;

  typedef struct {logic [31:0] data; logic last;} word_t;
  typedef struct {logic [127:0] din; logic [127:0] key; logic dec;} eng_t;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int max_gap = 1;
  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  word_t        exp_q [$];
  eng_t         eng_q [$];
  logic [127:0] blk_q [$];
  logic [127:0] pkt_out [$];
  logic [31:0]  pkt_words [$];
  logic [127:0] m_key = '0;
  logic [127:0] m_chain = '0;

  zynq_aes_top #(.DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tready(s00_axis_tready), .s00_axis_tlast(s00_axis_tlast),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tready(m00_axis_tready), .m00_axis_tlast(m00_axis_tlast),
    .eng_start(eng_start), .eng_decrypt(eng_decrypt), .eng_key(eng_key),
    .eng_din(eng_din), .eng_done(eng_done), .eng_dout(eng_dout)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference AES-128 ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = xb;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? inv_sbox[s[127-8*k -: 8]] : sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  // State byte k sits at row k%4, column k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
      if (!inv) begin
        o[127-32*c -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
        o[103-32*c -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
      end else begin
        o[127-32*c -: 8] = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
        o[119-32*c -: 8] = gmul(a0, 9) ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
        o[111-32*c -: 8] = gmul(a0, 13) ^ gmul(a1, 9) ^ gmul(a2, 14) ^ gmul(a3, 11);
        o[103-32*c -: 8] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9) ^ gmul(a3, 14);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_cipher(input logic [127:0] key, input logic [127:0] din, input bit dec);
    logic [31:0]  w [44];
    logic [127:0] rk [11];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    if (!dec) begin
      s = din ^ rk[0];
      for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
      s = shift_rows(sub_bytes(s, 0), 0) ^ rk[10];
    end else begin
      s = din ^ rk[10];
      for (int r = 9; r > 0; r--) s = mix_columns(sub_bytes(shift_rows(s, 1), 1) ^ rk[r], 1);
      s = sub_bytes(shift_rows(s, 1), 1) ^ rk[0];
    end
    return s;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    repeat ($urandom_range(0, max_gap)) @(posedge aclk);
    #1;
    s00_axis_tdata  = d;
    s00_axis_tlast  = l;
    s00_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (s00_axis_tready) break;
      n++;
      if (n > 3000) break;
    end
    if (!s00_axis_tready) checkOutput("in_ready_timeout", s00_axis_tready, 1);
    @(posedge aclk);
    #1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  // Builds one request packet from cmd/key/iv and blk_q, updates the model, then drives it.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [127:0] key, input logic [127:0] iv);
    word_t        in_q [$];
    word_t        wd;
    eng_t         e;
    logic [31:0]  cw;
    logic [127:0] b, din, r, o;
    int           nb;
    bit           dec, cbc;
    nb  = blk_q.size();
    dec = !cmd[0];
    cbc = cmd[2];
    pkt_out.delete();
    pkt_words.delete();
    cw = $urandom;
    cw[3:0] = cmd;
    in_q.push_back('{cw, nb == 0 && !cmd[1] && !cmd[3]});
    if (cmd[1]) begin
      for (int i = 0; i < 4; i++) in_q.push_back('{bswap(key[127-32*i -: 32]), i == 3 && nb == 0 && !cmd[3]});
      m_key = key;
    end
    if (cmd[3]) begin
      for (int i = 0; i < 4; i++) in_q.push_back('{bswap(iv[127-32*i -: 32]), i == 3 && nb == 0});
      m_chain = iv;
    end
    for (int k = 0; k < nb; k++) begin
      b = blk_q[k];
      for (int i = 0; i < 4; i++) in_q.push_back('{bswap(b[127-32*i -: 32]), k == nb - 1 && i == 3});
      din = (cbc && !dec) ? (b ^ m_chain) : b;
      e = '{din, m_key, dec};
      eng_q.push_back(e);
      r = aes_cipher(m_key, din, dec);
      o = (cbc && dec) ? (r ^ m_chain) : r;
      m_chain = dec ? b : r;
      pkt_out.push_back(o);
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{bswap(o[127-32*i -: 32]), k == nb - 1 && i == 3});
        pkt_words.push_back(bswap(o[127-32*i -: 32]));
      end
    end
    blk_q.delete();
    while (in_q.size() != 0) begin
      wd = in_q.pop_front();
      send_word(wd.data, wd.last);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || eng_q.size() != 0) && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    if (exp_q.size() != 0 || eng_q.size() != 0) begin
      checkOutput("drain_pending_words", exp_q.size(), 0);
      exp_q.delete();
      eng_q.delete();
    end
    repeat (12) @(posedge aclk);
  endtask

  // Emulated engine: reference AES with a random 1..6 cycle latency per block.
  initial begin
    eng_t         e;
    logic [127:0] r;
    int           lat;
    eng_done = 1'b0;
    eng_dout = '0;
    forever begin
      @(negedge aclk);
      if (eng_start && !areset) begin
        if (eng_q.size() == 0) begin
          checkOutput("spurious_eng_start", eng_start, 0);
          r = aes_cipher(eng_key, eng_din, eng_decrypt);
        end else begin
          e = eng_q.pop_front();
          checkOutput("eng_din", eng_din, e.din);
          checkOutput("eng_key", eng_key, e.key);
          checkOutput("eng_decrypt", eng_decrypt, e.dec);
          r = aes_cipher(e.key, e.din, e.dec);
        end
        lat = $urandom_range(1, 6);
        @(negedge aclk);
        checkOutput("eng_start_width", eng_start, 0);
        repeat (lat - 1) @(negedge aclk);
        eng_dout = r;
        eng_done = 1'b1;
        @(negedge aclk);
        eng_done = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    m00_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m00_axis_tready = 1'b1;
        1:       m00_axis_tready = (cyc % 8) >= 2;
        default: m00_axis_tready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Output scoreboard plus hold-during-stall check.
  initial begin
    word_t       w;
    bit          prev_stall;
    logic [31:0] pd;
    logic        pl;
    prev_stall = 0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall)
        checkOutput("stall_hold", {m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata}, {1'b1, pl, pd});
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_word", m00_axis_tvalid, 0);
        end else begin
          w = exp_q.pop_front();
          checkOutput("out_word", {m00_axis_tlast, m00_axis_tdata}, {w.last, w.data});
        end
      end
      prev_stall = m00_axis_tvalid && !m00_axis_tready;
      pd = m00_axis_tdata;
      pl = m00_axis_tlast;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] fips_key, fips_pt, fips_ct, cbc_iv;
    logic [127:0] pt [4];
    logic [127:0] ct_q [$];
    logic [3:0]   cmd;
    int           nb;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_pt  = 128'h00112233445566778899aabbccddeeff;
    fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    cbc_iv   = 128'h000102030405060708090a0b0c0d0e0f;
    init_tables();
    areset = 1'b1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
    s00_axis_tdata  = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("reset_s_tready", s00_axis_tready, 0);
    checkOutput("reset_m_tvalid", m00_axis_tvalid, 0);
    checkOutput("reset_m_tlast", m00_axis_tlast, 0);
    checkOutput("reset_eng_start", eng_start, 0);
    checkOutput("reset_eng_key", eng_key, 0);
    checkOutput("reset_eng_din", eng_din, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    checkOutput("model_fips_enc", aes_cipher(fips_key, fips_pt, 0), fips_ct);
    checkOutput("model_fips_dec", aes_cipher(fips_key, fips_ct, 1), fips_pt);

    $display("[TB] key-only packet, then ECB with that key");
    applyStimulus(4'h3, rand128(), '0);
    wait_drain();
    blk_q.push_back(rand128());
    applyStimulus(4'h1, '0, '0);
    wait_drain();

    $display("[TB] FIPS-197 ECB encrypt and decrypt");
    blk_q.push_back(fips_pt);
    applyStimulus(4'h3, fips_key, '0);
    checkOutput("model_fips_word0", pkt_words[0], 32'hd8e0c469);
    checkOutput("model_fips_word3", pkt_words[3], 32'h5ac5b470);
    wait_drain();
    blk_q.push_back(fips_ct);
    applyStimulus(4'h0, '0, '0);
    checkOutput("model_fips_plain", pkt_out[0], fips_pt);
    wait_drain();

    $display("[TB] CBC encrypt then decrypt, 4 blocks");
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      pt[i] = rand128();
      blk_q.push_back(pt[i]);
    end
    applyStimulus(4'hF, fips_key, cbc_iv);
    ct_q = pkt_out;
    wait_drain();
    blk_q = ct_q;
    // 0xE = KEY | CBC | IV with ENC clear: CBC decrypt reloading the same IV.
    applyStimulus(4'hE, fips_key, cbc_iv);
    for (int i = 0; i < 4; i++) checkOutput("model_cbc_roundtrip", pkt_out[i], pt[i]);
    wait_drain();

    $display("[TB] key packet truncated by tlast keeps the old key");
    send_word(32'h0000_0002, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    blk_q.push_back(rand128());
    applyStimulus(4'h1, '0, '0);
    wait_drain();

    $display("[TB] random packets with 2-low/6-high output ready and input gaps");
    ready_mode = 1;
    max_gap = 3;
    for (int p = 0; p < 8; p++) begin
      cmd = 4'($urandom);
      if (p == 0) cmd[1] = 1'b1;
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) blk_q.push_back(rand128());
      applyStimulus(cmd, rand128(), rand128());
    end
    wait_drain();

    $display("[TB] reset mid-block, then fresh ECB packet");
    ready_mode = 0;
    max_gap = 1;
    send_word(32'h0000_0001, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    m_key = '0;
    m_chain = '0;
    @(negedge aclk);
    checkOutput("midreset_s_tready", s00_axis_tready, 0);
    checkOutput("midreset_eng_key", eng_key, 0);
    checkOutput("midreset_m_tvalid", m00_axis_tvalid, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    blk_q.push_back(rand128());
    applyStimulus(4'h3, rand128(), '0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
